mem_access_stage: RTL and testbench
===================================

Name: mem_access_stage

Overview:
- MEM stage of the 5-stage MIPS pipeline. Sits between the EX/MEM register and mem_wb.
- Performs data-memory loads and stores against an internal word array with configurable multi-cycle latency.
- Stalls upstream while an access is in flight, and presents WBControl/ReadData/ALUResult/WriteReg to mem_wb.
- Outputs are combinational from stage state; mem_wb does the registering.

Parameters:
- ADDR_W, 10, word-index width; array depth = 2**ADDR_W words.
- MEM_LATENCY, 2, stall cycles per load/store; legal range 1..15.

Ports:
- clk  in  1  pipeline clock
- rst  in  1  synchronous active-high reset
- valid_in  in  1  EX/MEM holds a live instruction
- WBControl_in  in  2  [1]=memtoreg, [0]=regwrite
- MemRead  in  1  load
- MemWrite  in  1  store
- MemSize  in  2  00 word, 01 half, 10 byte (11 treated as word)
- MemSigned  in  1  sign-extend sub-word loads
- ALUResult_in  in  32  effective address / ALU result
- WriteData_in  in  32  store data (sub-word data in low bits)
- WriteReg_in  in  5  destination register
- stall  out  1  hold PC, IF/ID, ID/EX, EX/MEM this cycle
- misalign  out  1  current memory op misaligned; op suppressed
- WBControl  out  2  to mem_wb
- ReadData  out  32  to mem_wb
- ALUResult  out  32  to mem_wb, equals ALUResult_in
- WriteReg  out  5  to mem_wb, equals WriteReg_in

Behaviour:
- Reset: rst is synchronous and active-high, all on clk.
  - On reset: state=IDLE, counter=0, read buffer=0.
  - While rst=1: stall=0, misalign=0, WBControl=00, ReadData=0.
  - Array contents are not cleared.
- Definitions:
  - memop = valid_in & (MemRead|MemWrite) & !misalign.
  - Word index = ALUResult_in[ADDR_W+1:2]; upper address bits are ignored, so addresses wrap modulo depth.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - No memop: stall=0; WBControl=WBControl_in if valid_in, else 00; ReadData=0. Non-memory ops have zero added latency.
  - memop: stall=1, WBControl=00 (bubble into mem_wb). Load counter=MEM_LATENCY-1.
    - If MEM_LATENCY=1, go to DONE; otherwise go to BUSY.
- BUSY:
  - stall=1, WBControl=00, counter decrements each cycle.
  - At counter==1, go to DONE. On the edge entering DONE, the read buffer captures the addressed word.
- DONE:
  - stall=0, WBControl=WBControl_in.
  - ReadData = read buffer, formatted per MemSize/MemSigned; 0 for stores.
  - Stores commit on the edge ending DONE. Upstream advances on the same edge. Next state is IDLE.
- Total stall per memory op = MEM_LATENCY cycles; result is delivered in cycle MEM_LATENCY+1.
- MemRead & MemWrite both set: treat as store; ReadData=0.
- Misalignment:
  - Word with addr[1:0]!=0, or half with addr[0]!=0, sets misalign=1 combinationally.
  - No access and no stall; WBControl forced to 00; the instruction is dropped.
- Inputs are held stable by upstream while stall=1; the stage does not re-sample them.
- Reset during BUSY/DONE: abort, no store commits, state goes to IDLE.
- Byte lanes are big-endian: addr[1:0]=0 selects bits 31:24.

Optional Feature:
- MEM_SUBWORD_EN defined:
  - Byte/half loads extract the addressed lane and zero- or sign-extend per MemSigned.
  - Byte/half stores do read-modify-write of only the addressed lanes at the commit edge.
- MEM_SUBWORD_EN undefined:
  - MemSize and MemSigned are ignored; every access is a full word.
  - Misalignment is checked on addr[1:0] only.

Test Plan:
- MEM_LATENCY=2:
  - store 0xDEADBEEF to 0x40 -> stall=1 for 2 cycles, then WBControl=WBControl_in for 1 cycle.
  - Then load 0x40 with WBControl_in=11 -> stall 2 cycles, then ReadData=0xDEADBEEF, WBControl=11.
- Non-memory op (valid_in=1, WBControl_in=01, ALUResult_in=0x1234) -> stall=0, same-cycle pass-through, ReadData=0.
- Load word at 0x42 -> misalign=1, stall=0, WBControl=00, array unchanged.
- With MEM_SUBWORD_EN, word 0x80FF7F01 at 0x10:
  - lb 0x10 signed -> 0xFFFFFF80.
  - lbu 0x11 -> 0x000000FF.
  - lh 0x12 signed -> 0x00007F01.
  - sb 0xAA to 0x13 -> word becomes 0x80FF7FAA.
- Wrap, ADDR_W=10: store 0x11111111 to 0x1000, load 0x0000 -> ReadData=0x11111111.
- rst asserted during BUSY of a store to 0x20 -> state IDLE, stall=0 next cycle; later load of 0x20 returns the pre-store value.

Source files
------------

// File: rtl/mem_access_stage.sv
// MIPS MEM stage: each load/store stalls upstream MEM_LATENCY cycles and delivers in the next cycle; other ops pass through in the same cycle.
// Define MEM_SUBWORD_EN for big-endian byte/half lanes (read-modify-write stores); outputs are combinational for mem_wb.
module mem_access_stage #(
   parameter int ADDR_W      = 10,
   parameter int MEM_LATENCY = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        valid_in,
   input  logic [1:0]  WBControl_in,
   input  logic        MemRead,
   input  logic        MemWrite,
   input  logic [1:0]  MemSize,
   input  logic        MemSigned,
   input  logic [31:0] ALUResult_in,
   input  logic [31:0] WriteData_in,
   input  logic [4:0]  WriteReg_in,
   output logic        stall,
   output logic        misalign,
   output logic [1:0]  WBControl,
   output logic [31:0] ReadData,
   output logic [31:0] ALUResult,
   output logic [4:0]  WriteReg
);
   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   localparam int         DEPTH  = 2**ADDR_W;
   localparam logic [3:0] LAT_M1 = 4'(MEM_LATENCY - 1);

   state_t            r_state;
   state_t            w_next;
   logic [3:0]        r_cnt;
   logic [3:0]        w_cnt_next;
   logic [31:0]       r_rdbuf;
   logic [31:0]       r_mem [DEPTH];

   logic [ADDR_W-1:0] w_idx;
   logic [1:0]        w_lane;
   logic              w_access;
   logic              w_bad_addr;
   logic              w_mis;
   logic              w_memop;
   logic              w_capture;
   logic              w_commit;
   logic [31:0]       w_load_fmt;
   logic [31:0]       w_store_word;
   logic              w_unused;

   assign w_idx    = ALUResult_in[ADDR_W+1:2];
   assign w_lane   = ALUResult_in[1:0];
   assign w_access = valid_in & (MemRead | MemWrite);
   assign w_mis    = w_access & w_bad_addr;
   assign w_memop  = w_access & ~w_bad_addr;

   assign misalign  = ~rst & w_mis;
   assign ALUResult = ALUResult_in;
   assign WriteReg  = WriteReg_in;

`ifdef MEM_SUBWORD_EN
   logic [7:0]  w_byte;
   logic [15:0] w_half;

   always_comb begin
      w_bad_addr = (w_lane != 2'b00);
      case (MemSize)
         2'b01:   w_bad_addr = w_lane[0];
         2'b10:   w_bad_addr = 1'b0;
         default: ;
      endcase
   end

   // Lane 0 is the most significant byte; stores merge into the word captured on entry to DONE.
   always_comb begin
      w_byte = r_rdbuf[31:24];
      case (w_lane)
         2'd1:    w_byte = r_rdbuf[23:16];
         2'd2:    w_byte = r_rdbuf[15:8];
         2'd3:    w_byte = r_rdbuf[7:0];
         default: ;
      endcase
      w_half = w_lane[1] ? r_rdbuf[15:0] : r_rdbuf[31:16];

      w_load_fmt   = r_rdbuf;
      w_store_word = WriteData_in;
      case (MemSize)
         2'b01: begin
            w_load_fmt   = {{16{MemSigned & w_half[15]}}, w_half};
            w_store_word = r_rdbuf;
            if (w_lane[1]) w_store_word[15:0]  = WriteData_in[15:0];
            else           w_store_word[31:16] = WriteData_in[15:0];
         end
         2'b10: begin
            w_load_fmt   = {{24{MemSigned & w_byte[7]}}, w_byte};
            w_store_word = r_rdbuf;
            case (w_lane)
               2'd0:    w_store_word[31:24] = WriteData_in[7:0];
               2'd1:    w_store_word[23:16] = WriteData_in[7:0];
               2'd2:    w_store_word[15:8]  = WriteData_in[7:0];
               default: w_store_word[7:0]   = WriteData_in[7:0];
            endcase
         end
         default: ;
      endcase
   end

   assign w_unused = ^{ALUResult_in[31:ADDR_W+2]};
`else
   assign w_bad_addr   = (w_lane != 2'b00);
   assign w_load_fmt   = r_rdbuf;
   assign w_store_word = WriteData_in;
   assign w_unused     = ^{ALUResult_in[31:ADDR_W+2], MemSize, MemSigned};
`endif

   always_comb begin
      w_next     = r_state;
      w_cnt_next = r_cnt;
      stall      = 1'b0;
      WBControl  = 2'b00;
      ReadData   = 32'h0;
      w_capture  = 1'b0;
      w_commit   = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_memop) begin
               stall      = 1'b1;
               w_cnt_next = LAT_M1;
               if (MEM_LATENCY == 1) begin
                  w_next    = DONE;
                  w_capture = 1'b1;
               end else begin
                  w_next = BUSY;
               end
            end else if (valid_in && !w_mis) begin
               WBControl = WBControl_in;
            end
         end
         BUSY: begin
            stall      = 1'b1;
            w_cnt_next = r_cnt - 4'd1;
            if (r_cnt == 4'd1) begin
               w_next    = DONE;
               w_capture = 1'b1;
            end
         end
         DONE: begin
            WBControl = WBControl_in;
            ReadData  = MemWrite ? 32'h0 : w_load_fmt;
            w_commit  = MemWrite;
            w_next    = IDLE;
         end
         default: w_next = IDLE;
      endcase
      // Reset aborts any access in flight, including a pending store commit.
      if (rst) begin
         stall     = 1'b0;
         WBControl = 2'b00;
         ReadData  = 32'h0;
         w_commit  = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
         r_cnt   <= 4'd0;
         r_rdbuf <= 32'h0;
      end else begin
         r_state <= w_next;
         r_cnt   <= w_cnt_next;
         if (w_capture) r_rdbuf <= r_mem[w_idx];
      end
   end

   always_ff @(posedge clk) begin
      if (w_commit) r_mem[w_idx] <= w_store_word;
   end
endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage; a transaction-level memory model predicts every cycle's outputs.
module tb_mem_access_stage;
   localparam int AW  = 10;
   localparam int LAT = 2;
`ifdef MEM_SUBWORD_EN
   localparam bit SUBWORD = 1'b1;
`else
   localparam bit SUBWORD = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic        valid_in;
   logic [1:0]  WBControl_in;
   logic        MemRead;
   logic        MemWrite;
   logic [1:0]  MemSize;
   logic        MemSigned;
   logic [31:0] ALUResult_in;
   logic [31:0] WriteData_in;
   logic [4:0]  WriteReg_in;
   logic        stall;
   logic        misalign;
   logic [1:0]  WBControl;
   logic [31:0] ReadData;
   logic [31:0] ALUResult;
   logic [4:0]  WriteReg;

   always #5 clk = ~clk;

   mem_access_stage #(.ADDR_W(AW), .MEM_LATENCY(LAT)) dut (
      .clk(clk), .rst(rst), .valid_in(valid_in), .WBControl_in(WBControl_in),
      .MemRead(MemRead), .MemWrite(MemWrite), .MemSize(MemSize), .MemSigned(MemSigned),
      .ALUResult_in(ALUResult_in), .WriteData_in(WriteData_in), .WriteReg_in(WriteReg_in),
      .stall(stall), .misalign(misalign), .WBControl(WBControl), .ReadData(ReadData),
      .ALUResult(ALUResult), .WriteReg(WriteReg)
   );

   int          errors = 0;
   int          checks = 0;
   int          n_stall = 0;
   logic        chk_en = 1'b0;
   logic        e_stall, e_mis, e_rdchk;
   logic [1:0]  e_wbc;
   logic [31:0] e_rd;
   logic [31:0] obs_rd;
   logic        obs_mis;
   logic [31:0] mm [int];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: word index wraps modulo depth; lanes are big-endian.
   function automatic int m_idx(input logic [31:0] a);
      return int'((a / 4) % (2**AW));
   endfunction

   function automatic logic m_bad(input logic [31:0] a, input logic [1:0] sz);
      if (SUBWORD && sz == 2'b10) return 1'b0;
      if (SUBWORD && sz == 2'b01) return (a % 2) != 0;
      return (a % 4) != 0;
   endfunction

   function automatic logic [31:0] m_load(input logic [31:0] w, input logic [31:0] a,
                                          input logic [1:0] sz, input logic sg);
      logic [31:0] v;
      v = w;
      if (SUBWORD && sz == 2'b10) begin
         v = (w >> (8 * (3 - a % 4))) & 32'hFF;
         if (sg && v >= 32'h80) v = v - 32'h100;
      end else if (SUBWORD && sz == 2'b01) begin
         v = (w >> (16 * (1 - (a % 4) / 2))) & 32'hFFFF;
         if (sg && v >= 32'h8000) v = v - 32'h10000;
      end
      return v;
   endfunction

   function automatic logic [31:0] m_store(input logic [31:0] old, input logic [31:0] wd,
                                           input logic [31:0] a, input logic [1:0] sz);
      logic [31:0] mask;
      logic [31:0] sh;
      if (SUBWORD && sz == 2'b10) begin
         sh   = 8 * (3 - a % 4);
         mask = 32'hFF << sh;
         return (old & ~mask) | ((wd & 32'hFF) << sh);
      end else if (SUBWORD && sz == 2'b01) begin
         sh   = 16 * (1 - (a % 4) / 2);
         mask = 32'hFFFF << sh;
         return (old & ~mask) | ((wd & 32'hFFFF) << sh);
      end
      return wd;
   endfunction

   always @(negedge clk) begin
      if (chk_en) begin
         if (stall === 1'b1) n_stall++;
         chk("stall", 32'(stall), 32'(e_stall));
         chk("misalign", 32'(misalign), 32'(e_mis));
         chk("WBControl", 32'(WBControl), 32'(e_wbc));
         if (e_rdchk) chk("ReadData", ReadData, e_rd);
         chk("ALUResult", ALUResult, ALUResult_in);
         chk("WriteReg", 32'(WriteReg), 32'(WriteReg_in));
      end
   end

   task automatic step(input logic s, input logic m, input logic [1:0] w,
                       input logic rc, input logic [31:0] r);
      e_stall = s; e_mis = m; e_wbc = w; e_rdchk = rc; e_rd = r;
      chk_en = 1'b1;
      @(negedge clk);
      obs_rd  = ReadData;
      obs_mis = misalign;
      @(posedge clk);
      #1;
      chk_en = 1'b0;
   endtask

   task automatic drive(input logic v, input logic [1:0] wbc, input logic rd, input logic wr,
                        input logic [1:0] sz, input logic sg, input logic [31:0] a, input logic [31:0] wd);
      valid_in = v; WBControl_in = wbc; MemRead = rd; MemWrite = wr;
      MemSize = sz; MemSigned = sg; ALUResult_in = a; WriteData_in = wd;
      WriteReg_in = a[4:0] ^ 5'h15;
   endtask

   task automatic op(input logic v, input logic [1:0] wbc, input logic rd, input logic wr,
                     input logic [1:0] sz, input logic sg, input logic [31:0] a, input logic [31:0] wd);
      logic        bad;
      logic        known;
      logic [31:0] old;
      int          k;
      drive(v, wbc, rd, wr, sz, sg, a, wd);
      bad = v && (rd || wr) && m_bad(a, sz);
      k   = m_idx(a);
      if (!(v && (rd || wr)) || bad) begin
         step(1'b0, bad, (v && !bad) ? wbc : 2'b00, 1'b1, 32'h0);
      end else begin
         for (int i = 0; i < LAT; i++) step(1'b1, 1'b0, 2'b00, 1'b0, 32'h0);
         known = mm.exists(k);
         old   = known ? mm[k] : 32'h0;
         if (wr) begin
            step(1'b0, 1'b0, wbc, 1'b1, 32'h0);
            mm[k] = m_store(old, wd, a, sz);
         end else begin
            step(1'b0, 1'b0, wbc, known, m_load(old, a, sz, sg));
         end
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

   initial begin
      // Reset with a misaligned load presented: all outputs must stay quiet.
      rst = 1'b1;
      drive(1'b1, 2'b11, 1'b1, 1'b0, 2'b00, 1'b0, 32'h42, 32'h0);
      step(1'b0, 1'b0, 2'b00, 1'b1, 32'h0);
      step(1'b0, 1'b0, 2'b00, 1'b1, 32'h0);
      rst = 1'b0;

      n_stall = 0;
      op(1'b1, 2'b10, 1'b0, 1'b1, 2'b00, 1'b0, 32'h40, 32'hDEADBEEF);
      chk("sw40_stall_cycles", 32'(n_stall), 32'd2);
      n_stall = 0;
      op(1'b1, 2'b11, 1'b1, 1'b0, 2'b00, 1'b0, 32'h40, 32'h0);
      chk("lw40_stall_cycles", 32'(n_stall), 32'd2);
      chk("lw40_data", obs_rd, 32'hDEADBEEF);

      n_stall = 0;
      op(1'b1, 2'b01, 1'b0, 1'b0, 2'b00, 1'b0, 32'h1234, 32'h0);
      op(1'b0, 2'b11, 1'b0, 1'b0, 2'b00, 1'b0, 32'h8, 32'h0);
      chk("alu_ops_no_stall", 32'(n_stall), 32'd0);

      op(1'b1, 2'b11, 1'b1, 1'b0, 2'b00, 1'b0, 32'h42, 32'h0);
      chk("lw42_misalign", 32'(obs_mis), 32'd1);
      op(1'b1, 2'b00, 1'b0, 1'b1, 2'b00, 1'b0, 32'h41, 32'h0BADF00D);
      op(1'b1, 2'b11, 1'b1, 1'b0, 2'b00, 1'b0, 32'h40, 32'h0);
      chk("lw40_unchanged", obs_rd, 32'hDEADBEEF);

      op(1'b1, 2'b01, 1'b1, 1'b1, 2'b00, 1'b0, 32'h44, 32'h12345678);
      op(1'b1, 2'b11, 1'b1, 1'b0, 2'b00, 1'b0, 32'h44, 32'h0);
      chk("rw_both_store", obs_rd, 32'h12345678);

      op(1'b1, 2'b00, 1'b0, 1'b1, 2'b00, 1'b0, 32'h1000, 32'h11111111);
      op(1'b1, 2'b11, 1'b1, 1'b0, 2'b00, 1'b0, 32'h0000, 32'h0);
      chk("wrap_lw0", obs_rd, 32'h11111111);

`ifdef MEM_SUBWORD_EN
      op(1'b1, 2'b00, 1'b0, 1'b1, 2'b00, 1'b0, 32'h10, 32'h80FF7F01);
      op(1'b1, 2'b11, 1'b1, 1'b0, 2'b10, 1'b1, 32'h10, 32'h0);
      chk("lb10", obs_rd, 32'hFFFFFF80);
      op(1'b1, 2'b11, 1'b1, 1'b0, 2'b10, 1'b0, 32'h11, 32'h0);
      chk("lbu11", obs_rd, 32'h000000FF);
      op(1'b1, 2'b11, 1'b1, 1'b0, 2'b01, 1'b1, 32'h12, 32'h0);
      chk("lh12", obs_rd, 32'h00007F01);
      op(1'b1, 2'b11, 1'b1, 1'b0, 2'b01, 1'b1, 32'h10, 32'h0);
      chk("lh10", obs_rd, 32'hFFFF80FF);
      op(1'b1, 2'b00, 1'b0, 1'b1, 2'b10, 1'b0, 32'h13, 32'h000000AA);
      op(1'b1, 2'b11, 1'b1, 1'b0, 2'b00, 1'b0, 32'h10, 32'h0);
      chk("sb13_word", obs_rd, 32'h80FF7FAA);
      op(1'b1, 2'b00, 1'b0, 1'b1, 2'b01, 1'b0, 32'h10, 32'h1234BEEF);
      op(1'b1, 2'b11, 1'b1, 1'b0, 2'b11, 1'b0, 32'h10, 32'h0);
      chk("sh10_word", obs_rd, 32'hBEEF7FAA);
      op(1'b1, 2'b11, 1'b1, 1'b0, 2'b01, 1'b0, 32'h11, 32'h0);
      chk("lh11_misalign", 32'(obs_mis), 32'd1);
      op(1'b1, 2'b11, 1'b1, 1'b0, 2'b11, 1'b0, 32'h12, 32'h0);
      chk("size11_misalign", 32'(obs_mis), 32'd1);
`else
      op(1'b1, 2'b00, 1'b0, 1'b1, 2'b10, 1'b0, 32'h10, 32'hA5C3E781);
      op(1'b1, 2'b11, 1'b1, 1'b0, 2'b10, 1'b1, 32'h10, 32'h0);
      chk("byte_as_word", obs_rd, 32'hA5C3E781);
      op(1'b1, 2'b11, 1'b1, 1'b0, 2'b10, 1'b0, 32'h11, 32'h0);
      chk("byte11_misalign", 32'(obs_mis), 32'd1);
`endif

      // Reset in the middle of a store: the store must not commit.
      op(1'b1, 2'b00, 1'b0, 1'b1, 2'b00, 1'b0, 32'h20, 32'hCAFEF00D);
      n_stall = 0;
      drive(1'b1, 2'b00, 1'b0, 1'b1, 2'b00, 1'b0, 32'h20, 32'h55555555);
      step(1'b1, 1'b0, 2'b00, 1'b0, 32'h0);
      rst = 1'b1;
      drive(1'b0, 2'b00, 1'b0, 1'b0, 2'b00, 1'b0, 32'h20, 32'h0);
      step(1'b0, 1'b0, 2'b00, 1'b1, 32'h0);
      rst = 1'b0;
      step(1'b0, 1'b0, 2'b00, 1'b1, 32'h0);
      chk("rst_abort_stalls", 32'(n_stall), 32'd1);
      op(1'b1, 2'b11, 1'b1, 1'b0, 2'b00, 1'b0, 32'h20, 32'h0);
      chk("rst_abort_data", obs_rd, 32'hCAFEF00D);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
